regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the KGPRisc datapath, successor to the fixed 32x32 two-read/one-write file. It adds a second write port with defined priority, configurable read-port count, write-first bypass, an optional hard-wired zero register, and a synchronous initialisation sequencer that fills every entry after reset. It sits between decode (read addresses), writeback (write ports) and the ALU operand muxes.

## Interface
- DATA_W, 32, entry width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1: entry 0 always reads 0 and ignores writes
- INIT_MODE, 1, 0: init fills entries with 0; 1: entry i gets value i (zero-extended/truncated to DATA_W)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (priority over port 0)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- raddr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W]
- init_busy  out  1  high while init sequencer runs; writes dropped, reads return 0
- wr_conflict  out  1  registered one-cycle pulse: both ports wrote the same address on the previous edge

## Operation
- States: INIT, READY. Counter init_idx, ADDR_W+1 bits.
- rst high at an edge: state=INIT, init_idx=0, wr_conflict=0. No entry is written on a reset edge. Array contents otherwise undefined until init completes.
- INIT, rst low: each edge writes entry init_idx with its init value (INIT_MODE), init_idx++. Edge writing entry DEPTH-1 moves to READY.
- init_busy = (state==INIT), combinational from state; so 1 during reset and for exactly DEPTH edges after rst falls.
- rst asserted mid-INIT or in READY: restarts INIT from index 0; partially written contents are overwritten in sequence.
- READY writes: at edge, if we1, RF[waddr1]<=wdata1; if we0 and !(we1 && waddr1==waddr0), RF[waddr0]<=wdata0. Different addresses: both commit same edge.
- wr_conflict <= READY && we0 && we1 && waddr0==waddr1 (including address 0).
- ZERO_REG=1: writes to address 0 discarded on both ports; entry 0 init writes 0 regardless of INIT_MODE.
- Writes presented while init_busy=1 are dropped, no error flag.
- Reads (combinational, per port k): if init_busy -> 0; else if ZERO_REG && raddr_k==0 -> 0; else if we1 && waddr1==raddr_k -> wdata1; else if we0 && waddr0==raddr_k -> wdata0; else RF[raddr_k].
- All widths exact; no sign handling; INIT_MODE=1 value i truncated to DATA_W if DATA_W<ADDR_W.

## Timing
- Write latency: one edge; read-after-write in same cycle visible via bypass (write-first), from array from the next cycle.
- Read latency: zero cycles (combinational from raddr, we*, waddr*, wdata*, state).
- Post-reset availability: first usable write/read on cycle DEPTH+1 after rst falls (32 cycles of init_busy at defaults).
- wr_conflict: asserted in the cycle after the conflicting edge, for one cycle per conflicting edge; 0 during/after reset.
- Reset values: init_busy=1, wr_conflict=0, rdata=0 (all ports).

## Test plan
- Reset/init: rst high 2 cycles, release -> init_busy high exactly 32 cycles; then INIT_MODE=1 reads raddr=7 -> 7, raddr=31 -> 31, raddr=0 -> 0.
- Dual write: we0 addr 3 data 0xAAAA_0000, we1 addr 4 data 0x5555 same edge -> next cycle read 3 = 0xAAAA_0000, read 4 = 0x5555, wr_conflict=0.
- Conflict: both ports addr 9, wdata0=0x11, wdata1=0x22 -> RF[9]=0x22, wr_conflict=1 for one cycle then 0.
- Bypass: we0 addr 5 data 0xDEAD_BEEF with raddr port1=5 same cycle -> rdata port1=0xDEAD_BEEF before the edge; with we1 to 5 data 0x1 also -> 0x1.
- Zero register: write 0xFFFF_FFFF to addr 0 on both ports -> read 0 returns 0 that cycle and after; wr_conflict=1.
- Reset mid-operation: write 0x1234 to addr 10, assert rst at init_idx=15 of a later init -> init restarts, writes during init dropped, after completion addr 10 reads 10.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file for the KGPRisc datapath.
// Two write ports (port 1 wins on an address clash), NUM_RD combinational
// read ports with write-first bypass, optional hard-wired zero entry, and a
// sequencer that initialises every entry after reset.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; restarts the init sequence
//   we0/waddr0/wdata0  write port 0
//   we1/waddr1/wdata1  write port 1 (priority over port 0)
//   raddr        NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata        NUM_RD packed read data, port k at [k*DATA_W +: DATA_W]
//   init_busy    high while the init sequencer owns the array
//   wr_conflict  registered pulse: both ports hit the same address last edge
module regfile_mp #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned ZERO_REG  = 1,
    parameter int unsigned INIT_MODE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic                       init_busy,
    output logic                       wr_conflict
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned IDX_W = ADDR_W + 1;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_idx_q, init_idx_d;

    logic [DATA_W-1:0]  rf [DEPTH];

    logic               init_we;
    logic [ADDR_W-1:0]  init_addr;
    logic [DATA_W-1:0]  init_val;
    logic               wr0_en;
    logic               wr1_en;
    logic               same_addr;
    logic               zero_hit0;
    logic               zero_hit1;

    // State and init counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Next-state, init write generation and functional write enables
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        init_we    = 1'b0;
        init_addr  = init_idx_q[ADDR_W-1:0];
        init_val   = '0;
        wr0_en     = 1'b0;
        wr1_en     = 1'b0;

        same_addr  = (waddr0 == waddr1);
        zero_hit0  = (ZERO_REG != 0) && (waddr0 == '0);
        zero_hit1  = (ZERO_REG != 0) && (waddr1 == '0);

        unique case (state_q)
            ST_INIT: begin
                init_we    = 1'b1;
                init_idx_d = init_idx_q + IDX_W'(1);
                // Entry 0 stays zero when hard-wired, regardless of init mode
                if (INIT_MODE != 0 && !((ZERO_REG != 0) && init_addr == '0)) begin
                    init_val = DATA_W'(init_addr);
                end
                if (init_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                wr1_en = we1 && !zero_hit1;
                // Port 1 owns a shared address, so port 0 is suppressed there
                wr0_en = we0 && !zero_hit0 && !(we1 && same_addr);
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign init_busy = (state_q == ST_INIT);

    // Array storage; no write happens on a reset edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_we) begin
                rf[init_addr] <= init_val;
            end else begin
                if (wr1_en) begin
                    rf[waddr1] <= wdata1;
                end
                if (wr0_en) begin
                    rf[waddr0] <= wdata0;
                end
            end
        end
    end

    // Conflict pulse, counted even when the shared address is entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= (state_q == ST_READY) && we0 && we1 && same_addr;
        end
    end

    // Read ports with write-first bypass
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = rf[ra];
            if (init_busy) begin
                rd = '0;
            end else if ((ZERO_REG != 0) && ra == '0) begin
                rd = '0;
            end else if (we1 && waddr1 == ra) begin
                rd = wdata1;
            end else if (we0 && waddr0 == ra) begin
                rd = wdata0;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp at default parameters
// (32x32, two read ports, zero register, INIT_MODE=1).
module tb_regfile_mp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_RD = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic                     init_busy;
    logic                     wr_conflict;

    int n_vec  = 0;
    int n_miss = 0;
    int n_cyc;

    regfile_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1),
        .INIT_MODE(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we0        (we0),
        .waddr0     (waddr0),
        .wdata0     (wdata0),
        .we1        (we1),
        .waddr1     (waddr1),
        .wdata1     (wdata1),
        .raddr      (raddr),
        .rdata      (rdata),
        .init_busy  (init_busy),
        .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input int k, input logic [ADDR_W-1:0] a);
        raddr[k*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [DATA_W-1:0] rd(input int k);
        return rdata[k*DATA_W +: DATA_W];
    endfunction

    task automatic no_writes();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    endtask

    // Count edges until init_busy drops, bounded
    task automatic wait_init(output int cycles);
        cycles = 0;
        while (init_busy && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1;
        raddr = '0;
        no_writes();

        // Reset values
        tick();
        set_ra(0, 5'd7); set_ra(1, 5'd31);
        #1;
        check("rst_busy", 32'(init_busy), 32'd1);
        check("rst_conflict", 32'(wr_conflict), 32'd0);
        check("rst_rdata0", rd(0), 32'd0);
        check("rst_rdata1", rd(1), 32'd0);
        tick();

        // Init sequence length and INIT_MODE=1 contents
        rst = 1'b0;
        wait_init(n_cyc);
        check("init_cycles", 32'(n_cyc), 32'd32);
        #1;
        check("init_rd7", rd(0), 32'd7);
        check("init_rd31", rd(1), 32'd31);
        set_ra(0, 5'd0);
        #1;
        check("init_rd0", rd(0), 32'd0);

        // Dual write, distinct addresses
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hAAAA_0000;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h0000_5555;
        tick();
        no_writes();
        set_ra(0, 5'd3); set_ra(1, 5'd4);
        #1;
        check("dual_rd3", rd(0), 32'hAAAA_0000);
        check("dual_rd4", rd(1), 32'h0000_5555);
        check("dual_conflict", 32'(wr_conflict), 32'd0);

        // Same-address conflict: port 1 wins, one-cycle pulse
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h22;
        tick();
        no_writes();
        set_ra(0, 5'd9);
        #1;
        check("conf_pulse", 32'(wr_conflict), 32'd1);
        check("conf_rd9", rd(0), 32'h22);
        tick();
        check("conf_clear", 32'(wr_conflict), 32'd0);

        // Write-first bypass on read port 1
        set_ra(1, 5'd5);
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        #1;
        check("byp_we0", rd(1), 32'hDEAD_BEEF);
        we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h1;
        #1;
        check("byp_we1", rd(1), 32'h1);
        tick();
        no_writes();
        #1;
        check("byp_commit", rd(1), 32'h1);
        check("byp_conflict", 32'(wr_conflict), 32'd1);

        // Zero register ignores both ports but still flags the conflict
        set_ra(0, 5'd0);
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
        #1;
        check("zero_same", rd(0), 32'd0);
        tick();
        no_writes();
        #1;
        check("zero_after", rd(0), 32'd0);
        check("zero_conflict", 32'(wr_conflict), 32'd1);

        // Reset mid-init restarts from index 0 and drops writes
        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h1234;
        tick();
        no_writes();
        set_ra(0, 5'd10);
        #1;
        check("mid_pre_rd10", rd(0), 32'h1234);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hBEEF;
        #1;
        check("mid_busy_rd", rd(0), 32'd0);
        for (int i = 0; i < 15; i++) tick();
        check("mid_busy15", 32'(init_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init(n_cyc);
        check("mid_init_cycles", 32'(n_cyc), 32'd32);
        no_writes();
        set_ra(1, 5'd20);
        #1;
        check("mid_rd10", rd(0), 32'd10);
        check("mid_rd20", rd(1), 32'd20);
        set_ra(0, 5'd9); set_ra(1, 5'd5);
        #1;
        check("mid_rd9", rd(0), 32'd9);
        check("mid_rd5", rd(1), 32'd5);
        check("mid_conflict", 32'(wr_conflict), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
